gpio_port: RTL and testbench
============================

# gpio_port

Parametrised MSP430-style digital I/O port sitting between the peripheral bus and a bank of per-pin tri-state pad buffers. It holds the IN/OUT/DIR/SEL/IES/IE/IFG/IV register set for WIDTH pins and drives each pad buffer's I/T controls. Pad inputs pass through a synchroniser before they reach software or peripherals. Edge interrupts are generated with a priority-encoded vector whose read clears the serviced flag.

## Interface
- WIDTH, 8, number of pins (1..16)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- MCLK  input  1  system clock; all state updates on rising edge
- RST_n  input  1  asynchronous active-low reset
- addr  input  3  register select: 0 IN, 1 OUT, 2 DIR, 3 SEL, 4 IES, 5 IE, 6 IFG, 7 IV
- wdata  input  WIDTH  write data
- we  input  1  write strobe, one cycle per write
- re  input  1  read strobe, one cycle per read
- rdata  output  16  read data, zero-extended
- pad_i  output  WIDTH  to pad buffer I (value driven)
- pad_t  output  WIDTH  to pad buffer T (1 = high-Z)
- pad_o  input  WIDTH  from pad buffer O (asynchronous)
- per_out  input  WIDTH  peripheral output value when SEL=1
- per_oe  input  WIDTH  peripheral output enable when SEL=1
- per_in  output  WIDTH  synchronised pad value to peripherals
- irq  output  1  interrupt request, |(IFG & IE)

## Operation
- Pad mux per pin n: SEL[n]=0 -> pad_i=OUT[n], pad_t=~DIR[n]; SEL[n]=1 -> pad_i=per_out[n], pad_t=~per_oe[n]. Combinational.
- Synchroniser: SYNC_STAGES flops per pin, reset 0. Its output is IN, which is also driven onto per_in. A prev register holds the last IN.
- Edge detect: rise = IN & ~prev; fall = ~IN & prev. edge[n] = IES[n] ? fall[n] : rise[n]. Changing IES never creates an edge by itself.
- Arming counter: after RST_n deasserts, edges are masked for SYNC_STAGES+1 cycles so pins that are high at reset cause no spurious flag. The counter saturates; it is reset only by RST_n.
- IFG: a bit is set by edge[n] and is written by software at addr 6. If an edge and a software write to the same bit land in the same cycle, set wins.
- IV: reads 2*(k+1), where k is the lowest-index set bit of IFG & IE; reads 0 if none. A read with re at addr 7 clears IFG[k] at the next edge. A simultaneous new edge on bit k wins and leaves it set.
- Write with we: updates the selected register at the clock edge. Writes to IN and IV are ignored. Bits above WIDTH are ignored.
- Read with re: rdata is registered. It holds its value when re=0.
- Reset: OUT, DIR, SEL, IES, IE, IFG, sync, prev, rdata and counter all clear to 0. Result: pad_t all 1 (all pins high-Z), pad_i 0, irq 0, per_in 0.

## Timing
- Write: value is visible on the pad outputs in the same cycle the register updates, i.e. 1 edge after we.
- Read: rdata is valid 1 cycle after re. IV is sampled and cleared on that same edge.
- Pad change to IN/per_in: SYNC_STAGES edges.
- Pad change to IFG set and irq: SYNC_STAGES+1 edges. irq is combinational from IFG/IE.
- Pulses narrower than one MCLK period may be missed; this is not required to be caught.
- Asynchronous reset mid-operation forces every output to its reset value immediately, independent of MCLK.
- Back-to-back IV reads: each read clears one flag, highest priority first.

## Test plan
- Reset with pad_o=8'hFF held high -> pad_t=8'hFF, rdata=0, irq=0, and IFG reads 0 after 10 cycles (arming mask).
- Write DIR=8'h0F, OUT=8'hA5 -> pad_t=8'hF0 and pad_i=8'hA5 one edge later. Then write SEL=8'h01 with per_out[0]=0, per_oe[0]=1 -> pad_i[0]=0, pad_t[0]=0.
- IE=8'h08, IES=0, raise pad_o[3] -> IFG=8'h08 and irq=1 exactly 3 edges later (SYNC_STAGES=2). Falling edge on pad_o[3] sets nothing.
- IFG=8'h28 pending, IE=8'hFF -> IV reads 8, then 12, then 0. irq drops after the second read.
- Write IFG=0 in the same cycle an enabled edge arrives on bit 2 -> IFG[2]=1 afterwards. IV read coinciding with a new edge on the same bit -> bit stays set.
- Assert RST_n low mid-transfer with DIR=8'hFF -> pad_t=8'hFF asynchronously, before the next MCLK edge.

Source files
------------

// File: rtl/gpio_port.sv
// MSP430-style GPIO port: register bank, per-pin pad mux and input synchroniser,
// edge-triggered interrupt flags with a priority-encoded vector.

module gpio_pin #(
  parameter int SYNC_STAGES = 2
) (
  input  logic MCLK,
  input  logic RST_n,
  input  logic pad_o,
  input  logic out,
  input  logic dir,
  input  logic sel,
  input  logic ies,
  input  logic per_out,
  input  logic per_oe,
  output logic pad_i,
  output logic pad_t,
  output logic in_s,
  output logic edge_det
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad_o};
      prev <= in_s;
    end
  end

  assign in_s     = sync[SYNC_STAGES-1];
  // Edge is taken from the synchronised history only, so toggling IES alone never fires.
  assign edge_det = ies ? (~in_s & prev) : (in_s & ~prev);
  assign pad_i    = sel ? per_out : out;
  assign pad_t    = sel ? ~per_oe : ~dir;
endmodule

module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             MCLK,
  input  logic             RST_n,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic [15:0]      rdata,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] pad_o,
  input  logic [WIDTH-1:0] per_out,
  input  logic [WIDTH-1:0] per_oe,
  output logic [WIDTH-1:0] per_in,
  output logic             irq
);
  localparam int ARM = SYNC_STAGES + 1;
  localparam int CW  = $clog2(ARM + 1);

  typedef enum logic [2:0] {
    A_IN, A_OUT, A_DIR, A_SEL, A_IES, A_IE, A_IFG, A_IV
  } addr_e;

  logic [WIDTH-1:0] out_r, dir_r, sel_r, ies_r, ie_r, ifg_r, ifg_nxt;
  logic [WIDTH-1:0] in_s, edge_det, edge_v, pend, iv_clr;
  logic [CW-1:0]    arm_cnt;
  logic             armed, iv_hit, iv_rd;
  logic [4:0]       iv_idx;
  logic [15:0]      iv_val, rd_mux;

  for (genvar n = 0; n < WIDTH; n++) begin : g_pin
    gpio_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
      .MCLK    (MCLK),
      .RST_n   (RST_n),
      .pad_o   (pad_o[n]),
      .out     (out_r[n]),
      .dir     (dir_r[n]),
      .sel     (sel_r[n]),
      .ies     (ies_r[n]),
      .per_out (per_out[n]),
      .per_oe  (per_oe[n]),
      .pad_i   (pad_i[n]),
      .pad_t   (pad_t[n]),
      .in_s    (in_s[n]),
      .edge_det(edge_det[n])
    );
  end

  assign per_in = in_s;
  assign pend   = ifg_r & ie_r;
  assign irq    = |pend;

  // Hold off edge capture until the synchroniser and prev have flushed post-reset.
  assign armed  = (arm_cnt == CW'(ARM));
  assign edge_v = armed ? edge_det : '0;

  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n)      arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 1'b1;
  end

  // Lowest-index pending flag has priority.
  always_comb begin
    iv_hit = 1'b0;
    iv_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        iv_hit = 1'b1;
        iv_idx = i[4:0];
      end
    end
  end

  assign iv_val = iv_hit ? {10'd0, iv_idx + 5'd1, 1'b0} : 16'd0;
  assign iv_rd  = re && (addr == A_IV) && iv_hit;

  always_comb begin
    iv_clr = '0;
    for (int i = 0; i < WIDTH; i++) iv_clr[i] = iv_rd && (iv_idx == i[4:0]);
  end

  // Software write or IV clear first, then a fresh edge overrides either.
  always_comb begin
    ifg_nxt = ifg_r & ~iv_clr;
    if (we && addr == A_IFG) ifg_nxt = wdata;
    ifg_nxt = ifg_nxt | edge_v;
  end

  always_comb begin
    case (addr_e'(addr))
      A_IN:    rd_mux = 16'(in_s);
      A_OUT:   rd_mux = 16'(out_r);
      A_DIR:   rd_mux = 16'(dir_r);
      A_SEL:   rd_mux = 16'(sel_r);
      A_IES:   rd_mux = 16'(ies_r);
      A_IE:    rd_mux = 16'(ie_r);
      A_IFG:   rd_mux = 16'(ifg_r);
      default: rd_mux = iv_val;
    endcase
  end

  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      out_r <= '0;
      dir_r <= '0;
      sel_r <= '0;
      ies_r <= '0;
      ie_r  <= '0;
      ifg_r <= '0;
      rdata <= '0;
    end else begin
      ifg_r <= ifg_nxt;
      if (re) rdata <= rd_mux;
      if (we) begin
        case (addr_e'(addr))
          A_OUT:   out_r <= wdata;
          A_DIR:   dir_r <= wdata;
          A_SEL:   sel_r <= wdata;
          A_IES:   ies_r <= wdata;
          A_IE:    ie_r  <= wdata;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port (WIDTH=8, SYNC_STAGES=2) with hand-computed expectations.

module tb_gpio_port;
  logic        MCLK = 1'b0;
  logic        RST_n;
  logic [2:0]  addr;
  logic [7:0]  wdata, pad_o, per_out, per_oe;
  logic        we, re;
  logic [15:0] rdata;
  logic [7:0]  pad_i, pad_t, per_in;
  logic        irq;
  logic [15:0] rv;
  int          n_chk = 0;
  int          n_err = 0;

  gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .MCLK(MCLK), .RST_n(RST_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .pad_i(pad_i), .pad_t(pad_t), .pad_o(pad_o),
    .per_out(per_out), .per_oe(per_oe), .per_in(per_in), .irq(irq)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    d = rdata;
  endtask

  initial begin
    RST_n = 1'b0; addr = '0; wdata = '0; we = 0; re = 0;
    pad_o = 8'hFF; per_out = '0; per_oe = '0;
    #2;
    chk("rst_pad_t", 16'(pad_t), 16'h00FF);
    chk("rst_pad_i", 16'(pad_i), 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_irq", 16'(irq), 16'h0000);
    chk("rst_per_in", 16'(per_in), 16'h0000);
    #10 RST_n = 1'b1;
    tick(10);
    chk("arm_per_in", 16'(per_in), 16'h00FF);
    rd(3'd6, rv); chk("arm_ifg", rv, 16'h0000);
    rd(3'd0, rv); chk("arm_in", rv, 16'h00FF);
    pad_o = 8'h00;
    tick(4);
    rd(3'd6, rv); chk("fall_ies0_ifg", rv, 16'h0000);

    // Pad mux
    wr(3'd2, 8'h0F); chk("dir_pad_t", 16'(pad_t), 16'h00F0);
    wr(3'd1, 8'hA5); chk("out_pad_i", 16'(pad_i), 16'h00A5);
    per_out = 8'h00; per_oe = 8'h01;
    wr(3'd3, 8'h01);
    chk("sel_pad_i", 16'(pad_i), 16'h00A4);
    chk("sel_pad_t", 16'(pad_t), 16'h00F0);
    per_oe = 8'h00; #1;
    chk("sel_oe0_pad_t", 16'(pad_t), 16'h00F1);
    per_out = 8'h01; #1;
    chk("sel_po1_pad_i", 16'(pad_i), 16'h00A5);
    wr(3'd3, 8'h00);
    rd(3'd1, rv); chk("rd_out", rv, 16'h00A5);

    // Rising edge on pin 3, 3-edge latency
    wr(3'd5, 8'h08);
    pad_o = 8'h08;
    tick(2);
    chk("rise_irq_early", 16'(irq), 16'h0000);
    chk("rise_per_in", 16'(per_in), 16'h0008);
    tick();
    chk("rise_irq", 16'(irq), 16'h0001);
    rd(3'd6, rv); chk("rise_ifg", rv, 16'h0008);
    wr(3'd6, 8'h00);
    chk("ifg_clr_irq", 16'(irq), 16'h0000);
    pad_o = 8'h00;
    tick(4);
    rd(3'd6, rv); chk("fall3_ifg", rv, 16'h0000);

    // IV priority chain
    wr(3'd5, 8'hFF);
    wr(3'd6, 8'h28);
    chk("iv_irq0", 16'(irq), 16'h0001);
    rd(3'd7, rv); chk("iv_first", rv, 16'd8);
    chk("iv_irq1", 16'(irq), 16'h0001);
    rd(3'd7, rv); chk("iv_second", rv, 16'd12);
    chk("iv_irq2", 16'(irq), 16'h0000);
    rd(3'd7, rv); chk("iv_none", rv, 16'd0);
    wr(3'd7, 8'hFF);
    rd(3'd6, rv); chk("iv_wr_ignored", rv, 16'h0000);

    // Edge beats software write of IFG
    pad_o = 8'h04;
    tick(2);
    wr(3'd6, 8'h00);
    rd(3'd6, rv); chk("edge_vs_wr", rv, 16'h0004);
    wr(3'd6, 8'h00);
    pad_o = 8'h00;
    tick(4);
    rd(3'd6, rv); chk("pre_ivrace_ifg", rv, 16'h0000);

    // Edge beats IV clear on same bit
    wr(3'd6, 8'h04);
    pad_o = 8'h04;
    tick(2);
    rd(3'd7, rv); chk("ivrace_iv", rv, 16'd6);
    rd(3'd6, rv); chk("ivrace_ifg", rv, 16'h0004);

    // IES falling edge; changing IES alone sets nothing
    wr(3'd6, 8'h00);
    wr(3'd4, 8'h04);
    tick(2);
    rd(3'd6, rv); chk("ies_change", rv, 16'h0000);
    pad_o = 8'h00;
    tick(3);
    rd(3'd6, rv); chk("ies_fall", rv, 16'h0004);

    // Asynchronous reset mid-cycle
    wr(3'd2, 8'hFF);
    chk("dirff_pad_t", 16'(pad_t), 16'h0000);
    chk("pre_rst_irq", 16'(irq), 16'h0001);
    #2 RST_n = 1'b0;
    #1;
    chk("arst_pad_t", 16'(pad_t), 16'h00FF);
    chk("arst_pad_i", 16'(pad_i), 16'h0000);
    chk("arst_irq", 16'(irq), 16'h0000);
    chk("arst_rdata", rdata, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
